// File: rtl/result_serializer_if.sv
`default_nettype none
// ============================================================================
// Module  : result_serializer_if
// Brief   : Start/readback/UART bundle between the result serializer and its
//           neighbours.
// Revision: 1.0
// ============================================================================
interface result_serializer_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
);
  logic              start;
  logic [3:0]        matrix_size;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;
  logic [7:0]        tx_data;
  logic              tx_start;
  logic              tx_busy;
  logic              busy;
  logic              done;

  // The control unit, the result buffer and the UART drive the serializer.
  modport master (
    output start, matrix_size, rd_data, tx_busy,
    input  rd_addr, rd_en, tx_data, tx_start, busy, done
  );

  modport slave (
    input  start, matrix_size, rd_data, tx_busy,
    output rd_addr, rd_en, tx_data, tx_start, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/result_serializer.sv
`default_nettype none
// ============================================================================
// Module  : result_serializer
// Brief   : Streams an NxN 16-bit result matrix to a byte UART, high byte first.
// Revision: 1.0
// ============================================================================
module result_serializer #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
) (
  input  wire logic        clk,
  input  wire logic        rst,
  result_serializer_if.slave bus
);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_LATCH    = 4'd2,
    S_SEND_HI  = 4'd3,
    S_ACK_HI   = 4'd4,
    S_DRAIN_HI = 4'd5,
    S_SEND_LO  = 4'd6,
    S_ACK_LO   = 4'd7,
    S_DRAIN_LO = 4'd8,
    S_DONE     = 4'd9
  } state_t;

  state_t            state_q, state_d;
  logic [7:0]        index_q, index_d;
  logic [7:0]        total_q, total_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              rd_en_w;
  logic              tx_start_w;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      index_q   <= '0;
      total_q   <= '0;
      hold_q    <= '0;
      tx_data_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      index_q   <= index_d;
      total_q   <= total_d;
      hold_q    <= hold_d;
      tx_data_q <= tx_data_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    index_d    = index_q;
    total_d    = total_q;
    hold_d     = hold_q;
    tx_data_d  = tx_data_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    rd_en_w    = 1'b0;
    tx_start_w = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          total_d = {4'd0, bus.matrix_size} * {4'd0, bus.matrix_size};
          index_d = '0;
          busy_d  = 1'b1;
          state_d = (bus.matrix_size == 4'd0) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH: begin
        rd_en_w = 1'b1;
        state_d = S_LATCH;
      end
      S_LATCH: begin
        hold_d  = bus.rd_data;
        state_d = S_SEND_HI;
      end
      S_SEND_HI: begin
        if (!bus.tx_busy) begin
          tx_start_w = 1'b1;
          tx_data_d  = hold_q[DATA_W-1 -: 8];
          state_d    = S_ACK_HI;
        end
      end
      S_ACK_HI:   if (bus.tx_busy)  state_d = S_DRAIN_HI;
      S_DRAIN_HI: if (!bus.tx_busy) state_d = S_SEND_LO;
      S_SEND_LO: begin
        if (!bus.tx_busy) begin
          tx_start_w = 1'b1;
          tx_data_d  = hold_q[7:0];
          state_d    = S_ACK_LO;
        end
      end
      S_ACK_LO:   if (bus.tx_busy)  state_d = S_DRAIN_LO;
      S_DRAIN_LO: begin
        if (!bus.tx_busy) begin
          if (index_q == total_q - 8'd1) begin
            state_d = S_DONE;
          end else begin
            index_d = index_q + 8'd1;
            state_d = S_FETCH;
          end
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The new byte is presented in the tx_start cycle itself and then held.
  assign bus.tx_data  = tx_data_d;
  assign bus.tx_start = tx_start_w;
  assign bus.rd_en    = rd_en_w;
  assign bus.rd_addr  = ADDR_W'(index_q);
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

endmodule
`default_nettype wire

// File: tb/tb_result_serializer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : tb_result_serializer
// Brief   : Randomized bench for result_serializer with buffer and UART models.
// Revision: 1.0
// ============================================================================
module tb_result_serializer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  result_serializer_if #(.DATA_W(16), .ADDR_W(8)) ifc ();

  result_serializer #(.DATA_W(16), .ADDR_W(8)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Result buffer: registered read, data one cycle after rd_en.
  logic [15:0] mem [0:255];
  always @(posedge clk) if (ifc.rd_en) ifc.rd_data <= mem[ifc.rd_addr];

  // UART: busy for a random number of cycles per byte; pre_hold forces busy.
  int   uart_min = 1, uart_max = 1, uart_cnt = 0;
  logic uart_busy = 1'b0;
  logic pre_hold  = 1'b0;
  assign ifc.tx_busy = uart_busy | pre_hold;
  always @(posedge clk) begin
    if (ifc.tx_start) begin
      uart_busy <= 1'b1;
      uart_cnt  <= $urandom_range(uart_max, uart_min);
    end else if (uart_cnt > 1) begin
      uart_cnt <= uart_cnt - 1;
    end else begin
      uart_cnt  <= 0;
      uart_busy <= 1'b0;
    end
  end

  // Monitor, sampling on the falling edge.
  logic [7:0] rx_q [$];
  int   rd_addr_q [$];
  int   rd_cyc_q  [$];
  int   tx_count = 0, rd_count = 0, done_count = 0, cyc = 0, max_addr = 0;
  logic prev_start = 1'b0, prev_done = 1'b0;
  logic [7:0] last_byte = 8'h00;

  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      last_byte  = 8'h00;
      prev_start = 1'b0;
      prev_done  = 1'b0;
    end else begin
      if (ifc.tx_start) begin
        chk("start_while_busy", ifc.tx_busy, 1'b0);
        chk("start_back_to_back", prev_start, 1'b0);
        rx_q.push_back(ifc.tx_data);
        last_byte = ifc.tx_data;
        tx_count++;
      end else begin
        chk("tx_data_hold", ifc.tx_data, last_byte);
      end
      if (ifc.rd_en) begin
        rd_addr_q.push_back(int'(ifc.rd_addr));
        rd_cyc_q.push_back(cyc);
        if (int'(ifc.rd_addr) > max_addr) max_addr = int'(ifc.rd_addr);
        rd_count++;
      end
      if (ifc.done) begin
        chk("done_single_cycle", prev_done, 1'b0);
        chk("busy_low_at_done", ifc.busy, 1'b0);
        done_count++;
      end
      prev_start = ifc.tx_start;
      prev_done  = ifc.done;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic pulse_start(input int n);
    ifc.matrix_size = 4'(n);
    ifc.start       = 1'b1;
    tick(1);
    ifc.start       = 1'b0;
  endtask

  task automatic wait_done(input int d0, input int budget);
    int k = 0;
    while (done_count == d0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("done_within_budget", (done_count != d0), 1'b1);
    tick(1);
  endtask

  task automatic clear_logs();
    rx_q.delete();
    rd_addr_q.delete();
    rd_cyc_q.delete();
    max_addr = 0;
  endtask

  // Reference: every element, row-major, high byte then low byte.
  task automatic check_bytes(input string tag, input int n);
    logic [7:0] exp_q [$];
    for (int i = 0; i < n * n; i++) begin
      exp_q.push_back(mem[i][15:8]);
      exp_q.push_back(mem[i][7:0]);
    end
    chk({tag, "_byte_count"}, rx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
      chk($sformatf("%s_byte%0d", tag, i), rx_q[i], exp_q[i]);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_rd_addr"},  ifc.rd_addr,  8'd0);
    chk({tag, "_rd_en"},    ifc.rd_en,    1'b0);
    chk({tag, "_tx_data"},  ifc.tx_data,  8'd0);
    chk({tag, "_tx_start"}, ifc.tx_start, 1'b0);
    chk({tag, "_busy"},     ifc.busy,     1'b0);
    chk({tag, "_done"},     ifc.done,     1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
    $fatal(1);
  end

  initial begin
    int d0, t0, r0, k;
    ifc.start       = 1'b0;
    ifc.matrix_size = 4'd0;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;

    // Reset state
    rst = 1'b0;
    tick(3);
    @(negedge clk);
    check_reset_outputs("reset");
    tick(1);
    rst = 1'b1;
    tick(2);

    // N=2, fixed data, 10-cycle UART
    mem[0] = 16'h1234; mem[1] = 16'hABCD; mem[2] = 16'h0001; mem[3] = 16'hFF00;
    uart_min = 10; uart_max = 10;
    clear_logs();
    d0 = done_count;
    pulse_start(2);
    wait_done(d0, 2000);
    check_bytes("n2", 2);
    chk("n2_rd_count", rd_addr_q.size(), 4);
    for (int i = 0; i < rd_addr_q.size() && i < 4; i++)
      chk($sformatf("n2_rd_addr%0d", i), rd_addr_q[i], i);
    tick(5);
    chk("n2_done_count", done_count - d0, 1);
    chk("n2_busy_after", ifc.busy, 1'b0);

    // N=0: done two cycles after start, no traffic
    t0 = tx_count; r0 = rd_count; d0 = done_count;
    pulse_start(0);
    @(negedge clk);
    chk("n0_busy_c1", ifc.busy, 1'b1);
    chk("n0_done_c1", ifc.done, 1'b0);
    @(negedge clk);
    chk("n0_done_c2", ifc.done, 1'b1);
    tick(5);
    chk("n0_tx_count", tx_count - t0, 0);
    chk("n0_rd_count", rd_count - r0, 0);
    chk("n0_done_count", done_count - d0, 1);

    // N=3, UART held busy before start, random busy lengths
    for (int i = 0; i < 9; i++) mem[i] = 16'($urandom);
    uart_min = 1; uart_max = 20;
    clear_logs();
    pre_hold = 1'b1;
    tick(50);
    t0 = tx_count; d0 = done_count;
    pulse_start(3);
    tick(10);
    chk("n3_no_start_while_held", tx_count - t0, 0);
    pre_hold = 1'b0;
    wait_done(d0, 4000);
    check_bytes("n3", 3);

    // Second start mid-transfer with a different size is ignored
    for (int i = 0; i < 25; i++) mem[i] = 16'($urandom);
    clear_logs();
    t0 = tx_count; d0 = done_count;
    pulse_start(2);
    k = 0;
    while (tx_count - t0 < 2 && k < 500) begin tick(1); k++; end
    chk("restart_reached_byte2", (tx_count - t0 >= 2), 1'b1);
    pulse_start(5);
    wait_done(d0, 2000);
    tick(50);
    check_bytes("restart", 2);
    chk("restart_rd_count", rd_addr_q.size(), 4);
    chk("restart_done_count", done_count - d0, 1);

    // Reset after the third byte aborts; a fresh N=1 run then works
    for (int i = 0; i < 9; i++) mem[i] = 16'($urandom);
    clear_logs();
    t0 = tx_count; d0 = done_count;
    pulse_start(3);
    k = 0;
    while (tx_count - t0 < 3 && k < 2000) begin @(negedge clk); k++; end
    chk("abort_reached_byte3", tx_count - t0, 3);
    tick(1);
    rst = 1'b0;
    tick(1);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("abort");
    t0 = tx_count;
    tick(60);
    chk("abort_no_more_tx", tx_count - t0, 0);
    chk("abort_no_done", done_count - d0, 0);
    clear_logs();
    d0 = done_count;
    pulse_start(1);
    wait_done(d0, 500);
    check_bytes("after_abort", 1);

    // N=15, buffer[i]=i, ideal UART
    for (int i = 0; i < 225; i++) mem[i] = 16'(i);
    uart_min = 1; uart_max = 1;
    clear_logs();
    d0 = done_count;
    pulse_start(15);
    wait_done(d0, 5000);
    check_bytes("n15", 15);
    if (rx_q.size() >= 2) begin
      chk("n15_last_hi", rx_q[rx_q.size()-2], 8'h00);
      chk("n15_last_lo", rx_q[rx_q.size()-1], 8'hE0);
    end else begin
      chk("n15_last_pair_present", rx_q.size(), 450);
    end
    chk("n15_max_addr", max_addr, 224);
    chk("n15_rd_count", rd_addr_q.size(), 225);
    if (rd_cyc_q.size() >= 2)
      chk("n15_element_latency", rd_cyc_q[1] - rd_cyc_q[0], 8);
    else
      chk("n15_element_latency_samples", rd_cyc_q.size(), 225);
    tick(5);
    chk("n15_done_count", done_count - d0, 1);
    chk("n15_busy_after", ifc.busy, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
